// File: rtl/haz_pkg.sv
// Shared types, opcode constants and operand-use helpers for the hazard scoreboard.
// Opcode values are the RV32I major opcodes (instruction bits [6:0]).
package haz_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Forwarding source for a decode-stage operand
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_E   = 2'b01,
    FWD_M   = 2'b10,
    FWD_W   = 2'b11
  } fwd_sel_t;

  // Next-PC source for fetch
  typedef enum logic [1:0] {
    PC_PLUS4    = 2'b00,
    PC_JAL      = 2'b01,
    PC_REDIRECT = 2'b10
  } pc_sel_t;

  // Redirect squash state
  typedef enum logic {
    FS_IDLE     = 1'b0,
    FS_FLUSHING = 1'b1
  } flush_state_t;

  // rs1 is read by everything except the upper-immediate ops and JAL
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  endfunction

  // rs2 is read only by register-register ALU ops, stores and branches
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH);
  endfunction

  // Every op except stores and branches writes rd (rd == x0 is filtered by the caller)
  function automatic logic is_writer(input logic [6:0] op);
    return !(op == OPC_STORE || op == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/haz_flush_fsm.sv
// Redirect squash sequencer: holds FLUSH for FLUSH_LEN cycles per redirect,
// reloading the count if another redirect arrives while already flushing.
module haz_flush_fsm #(
  parameter int FLUSH_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic redirect_i,
  output logic flush_o
);
  import haz_pkg::*;

  // The redirect cycle itself is one flush cycle, so the counter covers the remainder
  localparam logic [2:0] RELOAD = 3'(FLUSH_LEN - 1);

  flush_state_t state_q, state_d;
  logic [2:0]   fcnt_q, fcnt_d;

  // Next-state and countdown for the squash window
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      FS_IDLE: begin
        if (redirect_i && (FLUSH_LEN > 1)) begin
          state_d = FS_FLUSHING;
          fcnt_d  = RELOAD;
        end
      end
      FS_FLUSHING: begin
        if (redirect_i) begin
          fcnt_d = RELOAD;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q == 3'd1) begin
            state_d = FS_IDLE;
          end
        end
      end
      default: begin
        state_d = FS_IDLE;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign flush_o = redirect_i || (state_q == FS_FLUSHING);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use scoreboard, E/M/W forwarding selects, redirect flush and PC select.
// Optional macro HAZ_PERF_EN adds saturating STALL_CNT / FLUSH_CNT outputs.
module hazard_scoreboard #(
  parameter int NREGS     = 32,
  parameter int AW        = 5,
  parameter int LOAD_LAT  = 2,
  parameter int FLUSH_LEN = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [6:0]    F_OP,
  input  logic          D_VALID,
  input  logic [AW-1:0] D_ADDR1,
  input  logic [AW-1:0] D_ADDR2,
  input  logic [AW-1:0] D_WADDR,
  input  logic [6:0]    D_OP,
  input  logic [AW-1:0] E_WADDR,
  input  logic [AW-1:0] M_WADDR,
  input  logic [AW-1:0] W_WADDR,
  input  logic [6:0]    E_OP,
  input  logic [6:0]    M_OP,
  input  logic [6:0]    W_OP,
  input  logic          REDIRECT,
  output logic          STALL,
  output logic          FLUSH,
  output logic [1:0]    FWD_RS1,
  output logic [1:0]    FWD_RS2,
  output logic [1:0]    PC_SEL
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]   STALL_CNT,
  output logic [31:0]   FLUSH_CNT
`endif
);
  import haz_pkg::*;

  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT);

  logic [CW-1:0] cnt_q [NREGS];
  logic [CW-1:0] cnt_d [NREGS];

  logic     flush_now;
  logic     stall_now;
  logic     issue;
  logic     rs1_busy, rs2_busy;
  logic     rs1_used, rs2_used;
  logic     e_fwd_ok, m_fwd_ok, w_fwd_ok;
  fwd_sel_t fwd_rs1, fwd_rs2;
  pc_sel_t  pc_sel;

  haz_flush_fsm #(
    .FLUSH_LEN(FLUSH_LEN)
  ) u_flush (
    .clk       (CLK),
    .rst_n     (RST_N),
    .redirect_i(REDIRECT),
    .flush_o   (flush_now)
  );

  // Picks the youngest stage that can supply a value for one operand
  function automatic fwd_sel_t fwd_pick(
    input logic          used,
    input logic [AW-1:0] addr,
    input logic          e_ok,
    input logic [AW-1:0] e_addr,
    input logic          m_ok,
    input logic [AW-1:0] m_addr,
    input logic          w_ok,
    input logic [AW-1:0] w_addr
  );
    fwd_sel_t sel;
    sel = FWD_REG;
    if (used && (addr != '0)) begin
      if (e_ok && (e_addr == addr)) begin
        sel = FWD_E;
      end else if (m_ok && (m_addr == addr)) begin
        sel = FWD_M;
      end else if (w_ok && (w_addr == addr)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  // Looks up the scoreboard for both decode sources; x0 is never busy
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if ((D_ADDR1 == AW'(i)) && (cnt_q[i] != '0)) begin
        rs1_busy = 1'b1;
      end
      if ((D_ADDR2 == AW'(i)) && (cnt_q[i] != '0)) begin
        rs2_busy = 1'b1;
      end
    end
  end

  // Load-use stall, suppressed while any flush is in progress
  always_comb begin
    rs1_used  = uses_rs1(D_OP);
    rs2_used  = uses_rs2(D_OP);
    stall_now = D_VALID && !flush_now &&
                ((rs1_used && rs1_busy) || (rs2_used && rs2_busy));
    issue     = D_VALID && !stall_now && !flush_now;
  end

  // Countdown per register; a new load issue overrides the decrement
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? (cnt_q[i] - CW'(1)) : '0;
    end
    cnt_d[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (issue && (D_OP == OPC_LOAD) && (D_WADDR == AW'(i))) begin
        cnt_d[i] = LOAD_VAL;
      end
    end
  end

  // Scoreboard registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Forwarding selects: load data only becomes available in W
  always_comb begin
    e_fwd_ok = is_writer(E_OP) && (E_OP != OPC_LOAD) && (E_WADDR != '0);
    m_fwd_ok = is_writer(M_OP) && (M_OP != OPC_LOAD) && (M_WADDR != '0);
    w_fwd_ok = is_writer(W_OP) && (W_WADDR != '0);
    fwd_rs1  = fwd_pick(rs1_used, D_ADDR1, e_fwd_ok, E_WADDR, m_fwd_ok, M_WADDR,
                        w_fwd_ok, W_WADDR);
    fwd_rs2  = fwd_pick(rs2_used, D_ADDR2, e_fwd_ok, E_WADDR, m_fwd_ok, M_WADDR,
                        w_fwd_ok, W_WADDR);
  end

  // Next-PC select: redirect beats a JAL in fetch, which only steers when F is live
  always_comb begin
    pc_sel = PC_PLUS4;
    if (REDIRECT) begin
      pc_sel = PC_REDIRECT;
    end else if ((F_OP == OPC_JAL) && !flush_now && !stall_now) begin
      pc_sel = PC_JAL;
    end
  end

  assign STALL   = stall_now;
  assign FLUSH   = flush_now;
  assign FWD_RS1 = fwd_rs1;
  assign FWD_RS2 = fwd_rs2;
  assign PC_SEL  = pc_sel;

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters for stall and flush cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_now && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush_now && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (LOAD_LAT=2, FLUSH_LEN=3).
// Expected output vectors are queued as stimulus is applied and popped when sampled.
module tb_hazard_scoreboard;

  localparam logic [6:0] NOP  = 7'b0000000;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OPR  = 7'b0110011;
  localparam logic [4:0] R0   = 5'd0;

  logic        CLK, RST_N;
  logic [6:0]  F_OP, D_OP, E_OP, M_OP, W_OP;
  logic        D_VALID, REDIRECT;
  logic [4:0]  D_ADDR1, D_ADDR2, D_WADDR, E_WADDR, M_WADDR, W_WADDR;
  logic        STALL, FLUSH;
  logic [1:0]  FWD_RS1, FWD_RS2, PC_SEL;
`ifdef HAZ_PERF_EN
  logic [31:0] STALL_CNT, FLUSH_CNT;
`endif

  // One cycle of stimulus plus the expected {stall, flush, fwd1, fwd2, pc_sel}
  typedef struct packed {
    logic [6:0] f_op;
    logic       dv;
    logic [6:0] d_op;
    logic [4:0] a1, a2, wa;
    logic [6:0] e_op;
    logic [4:0] e_wa;
    logic [6:0] m_op;
    logic [4:0] m_wa;
    logic [6:0] w_op;
    logic [4:0] w_wa;
    logic       redir;
    logic [7:0] exp_v;
  } step_t;

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall_cnt = 0;
  int exp_flush_cnt = 0;

  hazard_scoreboard #(
    .NREGS(32), .AW(5), .LOAD_LAT(2), .FLUSH_LEN(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .F_OP(F_OP), .D_VALID(D_VALID),
    .D_ADDR1(D_ADDR1), .D_ADDR2(D_ADDR2), .D_WADDR(D_WADDR), .D_OP(D_OP),
    .E_WADDR(E_WADDR), .M_WADDR(M_WADDR), .W_WADDR(W_WADDR),
    .E_OP(E_OP), .M_OP(M_OP), .W_OP(W_OP), .REDIRECT(REDIRECT),
    .STALL(STALL), .FLUSH(FLUSH), .FWD_RS1(FWD_RS1), .FWD_RS2(FWD_RS2),
    .PC_SEL(PC_SEL)
`ifdef HAZ_PERF_EN
    , .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic step_t mk(
    input logic [6:0] f_op, input logic dv, input logic [6:0] d_op,
    input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] wa,
    input logic [6:0] e_op, input logic [4:0] e_wa,
    input logic [6:0] m_op, input logic [4:0] m_wa,
    input logic [6:0] w_op, input logic [4:0] w_wa,
    input logic redir, input logic [7:0] ev);
    return '{f_op, dv, d_op, a1, a2, wa, e_op, e_wa, m_op, m_wa, w_op, w_wa, redir, ev};
  endfunction

  task automatic apply_stimulus(input step_t s);
    F_OP = s.f_op;   D_VALID = s.dv;   D_OP = s.d_op;
    D_ADDR1 = s.a1;  D_ADDR2 = s.a2;   D_WADDR = s.wa;
    E_OP = s.e_op;   E_WADDR = s.e_wa;
    M_OP = s.m_op;   M_WADDR = s.m_wa;
    W_OP = s.w_op;   W_WADDR = s.w_wa;
    REDIRECT = s.redir;
  endtask

  // Outputs under reset with idle inputs, and cleared perf counters
  task automatic test_reset();
    apply_stimulus(mk(NOP,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b0, 8'b0_0_00_00_00));
    RST_N = 1'b0;
    exp_q.push_back(8'b0_0_00_00_00);
    #3;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
      begin n_fail++; $display("[TB] FAIL reset_outputs: observed %b expected %b", {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
`ifdef HAZ_PERF_EN
    n_checks++;
    if (STALL_CNT !== 32'd0 || FLUSH_CNT !== 32'd0)
      begin n_fail++; $display("[TB] FAIL reset_perf: observed %0d/%0d expected 0/0", STALL_CNT, FLUSH_CNT); end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Back-to-back load-use: two stall cycles, then W forwarding; JAL in F held off while stalled
  task automatic test_load_use();
    step_t s[5];
    s[0] = mk(NOP,1'b1,LD ,5'd2,R0  ,5'd5, NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    s[1] = mk(JAL,1'b1,OPR,5'd5,5'd1,5'd6, LD ,5'd5,NOP,R0  ,NOP,R0  , 1'b0, 8'b1_0_00_00_00);
    s[2] = mk(JAL,1'b1,OPR,5'd5,5'd1,5'd6, NOP,R0  ,LD ,5'd5,NOP,R0  , 1'b0, 8'b1_0_00_00_00);
    s[3] = mk(JAL,1'b1,OPR,5'd5,5'd1,5'd6, NOP,R0  ,NOP,R0  ,LD ,5'd5, 1'b0, 8'b0_0_11_00_01);
    s[4] = mk(NOP,1'b0,NOP,R0  ,R0  ,R0  , NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(s[i]);
      exp_q.push_back(s[i].exp_v);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
        begin n_fail++; $display("[TB] FAIL load_use[%0d]: observed %b expected %b", i, {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
      @(negedge CLK);
      if (exp_v[7]) exp_stall_cnt++;
      if (exp_v[6]) exp_flush_cnt++;
    end
  endtask

  // Forwarding priority E > M > W, load exclusion in E/M, non-writers, unused operands
  task automatic test_forwarding();
    step_t s[11];
    s[0]  = mk(NOP,1'b1,OPR,5'd7,5'd3,5'd8, OPR,5'd3,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_01_00);
    s[1]  = mk(NOP,1'b1,OPR,5'd7,5'd3,5'd8, OPR,5'd3,OPR,5'd3,NOP,R0  , 1'b0, 8'b0_0_00_01_00);
    s[2]  = mk(NOP,1'b1,OPR,5'd7,5'd3,5'd8, NOP,R0  ,OPR,5'd3,NOP,R0  , 1'b0, 8'b0_0_00_10_00);
    s[3]  = mk(NOP,1'b1,OPR,5'd7,5'd3,5'd8, OPR,5'd7,NOP,R0  ,OPR,5'd3, 1'b0, 8'b0_0_01_11_00);
    s[4]  = mk(NOP,1'b1,LUI,5'd3,5'd3,5'd9, OPR,5'd3,OPR,5'd3,OPR,5'd3, 1'b0, 8'b0_0_00_00_00);
    s[5]  = mk(NOP,1'b1,OPR,5'd4,5'd3,5'd8, ST ,5'd3,BR ,5'd3,LD ,5'd3, 1'b0, 8'b0_0_00_11_00);
    s[6]  = mk(NOP,1'b1,ST ,5'd3,5'd3,R0  , LD ,5'd3,OPI,5'd3,NOP,R0  , 1'b0, 8'b0_0_10_10_00);
    s[7]  = mk(NOP,1'b1,BR ,5'd3,5'd4,R0  , JAL,5'd3,NOP,R0  ,OPR,5'd4, 1'b0, 8'b0_0_01_11_00);
    s[8]  = mk(NOP,1'b1,JAL,5'd3,5'd3,5'd1, OPR,5'd3,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    s[9]  = mk(NOP,1'b1,OPI,5'd3,5'd3,5'd8, OPR,5'd3,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_01_00_00);
    s[10] = mk(NOP,1'b0,NOP,R0  ,R0  ,R0  , NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(s[i]);
      exp_q.push_back(s[i].exp_v);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
        begin n_fail++; $display("[TB] FAIL forwarding[%0d]: observed %b expected %b", i, {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
      @(negedge CLK);
      if (exp_v[7]) exp_stall_cnt++;
      if (exp_v[6]) exp_flush_cnt++;
    end
  endtask

  // x0 is never hazardous or forwarded; a load without D_VALID is not tracked
  task automatic test_x0_and_valid();
    step_t s[5];
    s[0] = mk(NOP,1'b1,OPR,R0  ,R0  ,5'd8, OPR,R0  ,OPR,R0  ,LD ,R0  , 1'b0, 8'b0_0_00_00_00);
    s[1] = mk(NOP,1'b1,LD ,R0  ,R0  ,R0  , NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    s[2] = mk(NOP,1'b0,LD ,R0  ,R0  ,5'd9, NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    s[3] = mk(NOP,1'b1,OPR,5'd9,R0  ,5'd8, NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    s[4] = mk(NOP,1'b0,NOP,R0  ,R0  ,R0  , NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(s[i]);
      exp_q.push_back(s[i].exp_v);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
        begin n_fail++; $display("[TB] FAIL x0_valid[%0d]: observed %b expected %b", i, {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
      @(negedge CLK);
      if (exp_v[7]) exp_stall_cnt++;
      if (exp_v[6]) exp_flush_cnt++;
    end
  endtask

  // Single redirect: 3 flush cycles; second redirect on cycle 2 extends through cycle 4
  task automatic test_flush();
    step_t s[10];
    s[0] = mk(JAL,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b1, 8'b0_1_00_00_10);
    s[1] = mk(JAL,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b0, 8'b0_1_00_00_00);
    s[2] = mk(JAL,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b0, 8'b0_1_00_00_00);
    s[3] = mk(JAL,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b0, 8'b0_0_00_00_01);
    s[4] = mk(NOP,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b1, 8'b0_1_00_00_10);
    s[5] = mk(NOP,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b0, 8'b0_1_00_00_00);
    s[6] = mk(NOP,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b1, 8'b0_1_00_00_10);
    s[7] = mk(NOP,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b0, 8'b0_1_00_00_00);
    s[8] = mk(JAL,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b0, 8'b0_1_00_00_00);
    s[9] = mk(JAL,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b0, 8'b0_0_00_00_01);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(s[i]);
      exp_q.push_back(s[i].exp_v);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
        begin n_fail++; $display("[TB] FAIL flush[%0d]: observed %b expected %b", i, {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
      @(negedge CLK);
      if (exp_v[7]) exp_stall_cnt++;
      if (exp_v[6]) exp_flush_cnt++;
    end
  endtask

  // Redirect during a pending load-use stall overrides the stall
  task automatic test_redirect_stall();
    step_t s[7];
    s[0] = mk(NOP,1'b1,LD ,5'd2,R0  ,5'd5 , NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    s[1] = mk(NOP,1'b1,OPR,5'd5,5'd1,5'd6 , LD ,5'd5,NOP,R0  ,NOP,R0  , 1'b0, 8'b1_0_00_00_00);
    s[2] = mk(NOP,1'b1,LD ,5'd5,R0  ,5'd10, NOP,R0  ,LD ,5'd5,NOP,R0  , 1'b1, 8'b0_1_00_00_10);
    s[3] = mk(NOP,1'b0,NOP,R0  ,R0  ,R0   , NOP,R0  ,NOP,R0  ,LD ,5'd5, 1'b0, 8'b0_1_00_00_00);
    s[4] = mk(NOP,1'b0,NOP,R0  ,R0  ,R0   , NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_1_00_00_00);
    s[5] = mk(NOP,1'b0,NOP,R0  ,R0  ,R0   , NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    s[6] = mk(NOP,1'b1,OPR,5'd10,R0 ,5'd8 , NOP,R0  ,NOP,R0  ,NOP,R0  , 1'b0, 8'b0_0_00_00_00);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(s[i]);
      exp_q.push_back(s[i].exp_v);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
        begin n_fail++; $display("[TB] FAIL redirect_stall[%0d]: observed %b expected %b", i, {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
      @(negedge CLK);
      if (exp_v[7]) exp_stall_cnt++;
      if (exp_v[6]) exp_flush_cnt++;
    end
  endtask

  // Asynchronous reset in the middle of a stall and in the middle of a flush
  task automatic test_reset_mid();
    step_t s[2];
    s[0] = mk(NOP,1'b1,LD ,5'd2,R0  ,5'd5, NOP,R0  ,NOP,R0,NOP,R0, 1'b0, 8'b0_0_00_00_00);
    s[1] = mk(NOP,1'b1,OPR,5'd5,5'd1,5'd6, LD ,5'd5,NOP,R0,NOP,R0, 1'b0, 8'b1_0_00_00_00);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(s[i]);
      exp_q.push_back(s[i].exp_v);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
        begin n_fail++; $display("[TB] FAIL reset_mid_pre[%0d]: observed %b expected %b", i, {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
      @(negedge CLK);
      if (exp_v[7]) exp_stall_cnt++;
      if (exp_v[6]) exp_flush_cnt++;
    end
    // cnt[x5] is 1 here: still stalling
    apply_stimulus(mk(NOP,1'b1,OPR,5'd5,5'd1,5'd6, NOP,R0,LD,5'd5,NOP,R0, 1'b0, 8'b0));
    exp_q.push_back(8'b1_0_00_00_00);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
      begin n_fail++; $display("[TB] FAIL stall_before_reset: observed %b expected %b", {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
`ifdef HAZ_PERF_EN
    n_checks++;
    if (STALL_CNT !== 32'(exp_stall_cnt) || FLUSH_CNT !== 32'(exp_flush_cnt))
      begin n_fail++; $display("[TB] FAIL perf_counts: observed %0d/%0d expected %0d/%0d", STALL_CNT, FLUSH_CNT, exp_stall_cnt, exp_flush_cnt); end
`endif
    #1 RST_N = 1'b0;
    exp_q.push_back(8'b0_0_00_00_00);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
      begin n_fail++; $display("[TB] FAIL stall_drop_on_reset: observed %b expected %b", {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
`ifdef HAZ_PERF_EN
    n_checks++;
    if (STALL_CNT !== 32'd0 || FLUSH_CNT !== 32'd0)
      begin n_fail++; $display("[TB] FAIL perf_cleared: observed %0d/%0d expected 0/0", STALL_CNT, FLUSH_CNT); end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    apply_stimulus(mk(NOP,1'b1,OPR,5'd5,5'd1,5'd6, NOP,R0,NOP,R0,NOP,R0, 1'b0, 8'b0));
    exp_q.push_back(8'b0_0_00_00_00);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
      begin n_fail++; $display("[TB] FAIL no_stall_after_reset: observed %b expected %b", {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
    @(negedge CLK);
    // Reset while flushing, with REDIRECT already low
    apply_stimulus(mk(NOP,1'b0,NOP,R0,R0,R0, NOP,R0,NOP,R0,NOP,R0, 1'b1, 8'b0));
    exp_q.push_back(8'b0_1_00_00_10);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
      begin n_fail++; $display("[TB] FAIL flush_start: observed %b expected %b", {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
    @(negedge CLK);
    REDIRECT = 1'b0;
    exp_q.push_back(8'b0_1_00_00_00);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
      begin n_fail++; $display("[TB] FAIL flushing_before_reset: observed %b expected %b", {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
    #1 RST_N = 1'b0;
    exp_q.push_back(8'b0_0_00_00_00);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
      begin n_fail++; $display("[TB] FAIL flush_drop_on_reset: observed %b expected %b", {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
    @(negedge CLK);
    RST_N = 1'b1;
    exp_q.push_back(8'b0_0_00_00_00);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL} !== exp_v)
      begin n_fail++; $display("[TB] FAIL idle_after_reset: observed %b expected %b", {STALL, FLUSH, FWD_RS1, FWD_RS2, PC_SEL}, exp_v); end
    @(negedge CLK);
  endtask

  initial begin
    $display("[TB] hazard_scoreboard bench start");
    test_reset();
    test_load_use();
    test_forwarding();
    test_x0_and_valid();
    test_flush();
    test_redirect_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the 5-stage hazard unit. Tracks in-flight load destinations in a per-register countdown scoreboard, so load-use stall length is a parameter rather than fixed at one cycle.
- Produces E/M/W forwarding selects for the decode-stage operands.
- Runs a redirect/flush state machine that squashes a configurable number of younger stages.
- Sits beside the pipeline registers and is driven by stage addresses and opcodes from opcodes.svh.

Parameters:
- NREGS, 32, architectural register count; x0 is never tracked.
- AW, 5, register address width; must satisfy 2**AW >= NREGS.
- LOAD_LAT, 2, stall cycles for a back-to-back load-use; load data is forwardable only from W. Range 1..7.
- FLUSH_LEN, 2, cycles FLUSH stays high per redirect. Range 1..7.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- F_OP  in  7  fetch-stage opcode.
- D_VALID  in  1  decode holds a real instruction.
- D_ADDR1, D_ADDR2, D_WADDR  in  AW each  decode rs1/rs2/rd.
- D_OP  in  7  decode opcode.
- E_WADDR, M_WADDR, W_WADDR  in  AW each  stage rd.
- E_OP, M_OP, W_OP  in  7  stage opcodes.
- REDIRECT  in  1  taken branch or JALR resolved in E this cycle.
- STALL  out  1  hold F and D, bubble into E.
- FLUSH  out  1  squash F and D.
- FWD_RS1, FWD_RS2  out  2 each  00 regfile, 01 E, 10 M, 11 W.
- PC_SEL  out  2  00 PC+4, 01 JAL target, 10 redirect target.

Behaviour:
- Operand use:
  - rs1 is used unless D_OP is LUI, AUIPC or JAL.
  - rs2 is used only for OP, STORE and BRANCH.
  - An operand with address 0 is never hazardous.
- Writer: any stage op other than STORE or BRANCH with WADDR != 0.
- Scoreboard:
  - One counter per register, width $clog2(LOAD_LAT+1), held in a reg array.
  - issue = D_VALID && !STALL && !FLUSH.
  - On issue with D_OP == LOAD and D_WADDR != 0: cnt[D_WADDR] <= LOAD_LAT.
  - All other nonzero counters decrement by 1 each cycle.
  - Issue and decrement on the same entry in the same cycle: issue wins.
- STALL (combinational):
  - Asserted when D_VALID, no flush is in progress, and any used source register has cnt != 0.
  - A back-to-back load-use therefore stalls exactly LOAD_LAT cycles.
- Forwarding (combinational), per used operand, first match wins:
  - E, if E is a writer, E_OP != LOAD and the address matches.
  - Else M, under the same rule.
  - Else W, for any writer including LOAD.
  - Else 00. Unused operands always give 00.
- Flush FSM, states IDLE and FLUSHING, 3-bit counter fcnt:
  - IDLE: on REDIRECT go to FLUSHING with fcnt <= FLUSH_LEN-1 if FLUSH_LEN > 1; otherwise stay in IDLE.
  - FLUSHING: fcnt decrements each cycle; at fcnt == 1 (after the decrement to 0) return to IDLE.
  - REDIRECT while FLUSHING reloads fcnt to FLUSH_LEN-1.
  - FLUSH = REDIRECT || (state == FLUSHING).
- Flush vs stall: FLUSH forces STALL = 0 and blocks scoreboard issue. Loads already in E, M or W keep their counters.
- PC_SEL: 10 if REDIRECT; else 01 if F_OP == JAL and no flush or stall; else 00.
- Reset (asynchronous, at any time, including mid-flush or mid-stall):
  - All counters 0 and state IDLE.
  - Outputs settle to STALL 0, FLUSH 0, FWD_RS1 00, FWD_RS2 00, PC_SEL 00 once inputs are idle.

Optional Feature:
- Macro: HAZ_PERF_EN.
- With it defined, the block adds outputs STALL_CNT[31:0] and FLUSH_CNT[31:0]:
  - Each increments on every cycle its signal is high.
  - Both saturate at all ones.
  - Both are cleared by RST_N.
- Without it, neither the ports nor the counters exist.

Decomposition:
- Shared package haz_pkg:
  - typedef fwd_sel_t, an enum of FWD_REG, FWD_E, FWD_M, FWD_W.
  - typedef pc_sel_t.
  - typedef flush_state_t.
  - Functions uses_rs1, uses_rs2 and is_writer, taking an opcode.
- Opcode constants stay in opcodes.svh.
- Sub-module haz_flush_fsm (state register, fcnt, FLUSH) is instantiated once.

Test Plan:
- Load then use, LOAD_LAT=2: LOAD x5 issued, next D is ADD x6,x5,x1 -> STALL high for 2 cycles, then FWD_RS1=11 as the load reaches W.
- ADD x3 in E, SUB using x3 as rs2 in D -> STALL 0, FWD_RS2=01. Same x3 also in M -> still 01, E wins.
- D rs1=x0 while E writes x0 -> FWD_RS1=00, STALL 0.
- REDIRECT pulse with FLUSH_LEN=3 -> FLUSH high 3 cycles, PC_SEL=10 on the first cycle only. Second REDIRECT on cycle 2 -> FLUSH extends through cycle 4.
- REDIRECT while a load-use stall is pending -> STALL 0, FLUSH 1, no scoreboard entry for the flushed D load.
- RST_N low mid-stall, cnt[x5]=1 -> STALL drops immediately; after release, a dependent op on x5 sees no stall. With HAZ_PERF_EN, STALL_CNT reads 0.
